// File: rtl/mod_pkg.sv
// Shared definitions for the repeated-subtraction modulo unit: the 2-bit
// datapath command encoding and the control FSM state set.
package mod_pkg;

    // Commands driven on the state bus towards the datapath
    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_SUB   = 2'b01;
    localparam logic [1:0] CMD_FINAL = 2'b10;
    localparam logic [1:0] CMD_HOLD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SUB,
        FINAL,
        DONE
    } fsm_e;

    // Datapath command issued while the controller sits in a given state
    function automatic logic [1:0] cmd_of(input fsm_e s);
        logic [1:0] c;
        case (s)
            LOAD:    c = CMD_LOAD;
            SUB:     c = CMD_SUB;
            FINAL:   c = CMD_FINAL;
            default: c = CMD_HOLD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod_iter_cnt.sv
// Clear/increment/hold counter used as the quotient register. Clear wins
// over increment. at_lim_o flags that the count equals LIMIT.
module mod_iter_cnt #(
    parameter int             W     = 32,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         at_lim_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, step by one, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_lim_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mod_cu.sv
// Control unit for the repeated-subtraction modulo datapath.
// Sequences LOAD -> (CHECK -> SUB)* -> CHECK -> FINAL -> DONE, watching the
// datapath flag x (temp < b) in CHECK only. The quotient is the number of
// SUB commands issued. Hitting MAX_ITER or a zero divisor ends with err.
// Optional feature: define MOD_CU_ABORT_EN to add an abort input that ends
// a running operation early with err (FINAL is skipped).
module mod_cu
    import mod_pkg::*;
#(
    parameter int          ITER_W   = 32,
    parameter logic [31:0] MAX_ITER = 32'd1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              b_zero,
`ifdef MOD_CU_ABORT_EN
    input  logic              abort,
`endif
    input  logic              x,
    output logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] quotient
);

    // The quotient never wraps, so the limit must be representable
    generate
        if ((64'(MAX_ITER) >> ITER_W) != 64'd0) begin : g_max_iter_too_wide
            $error("mod_cu: MAX_ITER=%0d does not fit in ITER_W=%0d bits", MAX_ITER, ITER_W);
        end
    endgenerate

    fsm_e        fsm_q, fsm_d;
    logic        err_q, err_d;
    logic [1:0]  state_q;
    logic        busy_q;
    logic        done_q;

    logic        cnt_clr;
    logic        cnt_inc;
    logic        at_max;

    // Quotient is cleared while LOAD is issued and bumped once per SUB
    assign cnt_clr = (fsm_q == LOAD);
    assign cnt_inc = (fsm_q == SUB);

    mod_iter_cnt #(
        .W     (ITER_W),
        .LIMIT (ITER_W'(MAX_ITER))
    ) u_quot (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .cnt_o    (quotient),
        .at_lim_o (at_max)
    );

    // Next-state and error-flag selection
    always_comb begin
        fsm_d = fsm_q;
        err_d = err_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    if (b_zero) begin
                        fsm_d = DONE;
                        err_d = 1'b1;
                    end else begin
                        fsm_d = LOAD;
                        err_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                fsm_d = CHECK;
            end
            CHECK: begin
                if (x) begin
                    fsm_d = FINAL;
                end else if (at_max) begin
                    fsm_d = DONE;
                    err_d = 1'b1;
                end else begin
                    fsm_d = SUB;
                end
            end
            SUB: begin
                fsm_d = CHECK;
            end
            FINAL: begin
                fsm_d = DONE;
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
`ifdef MOD_CU_ABORT_EN
        if (abort && ((fsm_q == LOAD) || (fsm_q == CHECK) || (fsm_q == SUB))) begin
            fsm_d = DONE;
            err_d = 1'b1;
        end
`endif
    end

    // FSM register with outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            err_q   <= 1'b0;
            state_q <= CMD_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            err_q   <= err_d;
            state_q <= cmd_of(fsm_d);
            busy_q  <= (fsm_d != IDLE);
            done_q  <= (fsm_d == DONE);
        end
    end

    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mod_cu.sv
// Bench for mod_cu: two controller instances (default limit and MAX_ITER=4),
// each closed around a small behavioural subtract datapath. Expected results
// are queued at stimulus time and popped by per-instance monitors on done.
module tb_mod_cu;
    import mod_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic        er;
        logic        chk_res;
        logic [31:0] res;
        int          lat;
        int          e0;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic        start_a, bz_a, x_a, busy_a, done_a, err_a;
    logic [1:0]  st_a;
    logic [31:0] q_a, a_a, b_a, temp_a, res_a;

    // Instance B: MAX_ITER = 4
    logic        start_b, bz_b, x_b, busy_b, done_b, err_b;
    logic [1:0]  st_b;
    logic [31:0] q_b, a_b, b_b, temp_b, res_b;

    mod_cu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .b_zero   (bz_a),
`ifdef MOD_CU_ABORT_EN
        .abort    (1'b0),
`endif
        .x        (x_a),
        .state    (st_a),
        .busy     (busy_a),
        .done     (done_a),
        .err      (err_a),
        .quotient (q_a)
    );

    mod_cu #(.ITER_W(32), .MAX_ITER(32'd4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .b_zero   (bz_b),
`ifdef MOD_CU_ABORT_EN
        .abort    (1'b0),
`endif
        .x        (x_b),
        .state    (st_b),
        .busy     (busy_b),
        .done     (done_b),
        .err      (err_b),
        .quotient (q_b)
    );

    // Behavioural datapaths (temp is deliberately not reset)
    assign x_a = (temp_a < b_a);
    assign x_b = (temp_b < b_b);

    always @(posedge clk) begin
        case (st_a)
            CMD_LOAD:  temp_a <= a_a;
            CMD_SUB:   temp_a <= temp_a - b_a;
            CMD_FINAL: res_a  <= temp_a;
            default: ;
        endcase
        case (st_b)
            CMD_LOAD:  temp_b <= a_b;
            CMD_SUB:   temp_b <= temp_b - b_b;
            CMD_FINAL: res_b  <= temp_b;
            default: ;
        endcase
    end

    exp_t       sb_a[$];
    exp_t       sb_b[$];
    logic [1:0] tr_a[$];
    logic [1:0] tr_b[$];
    int         done_cnt_a = 0;
    int         done_cnt_b = 0;
    int         vectors = 0;
    int         miscmp  = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        vectors++;
        if (act !== expv) begin
            miscmp++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic check_done(input exp_t e, input logic [31:0] q, input logic er,
                              input logic [31:0] res);
        chk({e.name, " quotient"}, q, e.q);
        chk({e.name, " err"}, er, e.er);
        if (e.chk_res) chk({e.name, " result"}, res, e.res);
        chk({e.name, " done cycle"}, cyc - e.e0 + 1, e.lat);
    endtask

    // Monitor A: trace the command bus while busy, score on done
    always @(negedge clk) begin
        exp_t e;
        if (busy_a) tr_a.push_back(st_a);
        if (done_a) begin
            if (sb_a.size() == 0) begin
                vectors++;
                miscmp++;
                $display("FAIL dut unexpected done: quotient %0d err %0d, expected no done", q_a, err_a);
            end else begin
                e = sb_a.pop_front();
                check_done(e, q_a, err_a, res_a);
            end
            done_cnt_a++;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (busy_b) tr_b.push_back(st_b);
        if (done_b) begin
            if (sb_b.size() == 0) begin
                vectors++;
                miscmp++;
                $display("FAIL dut4 unexpected done: quotient %0d err %0d, expected no done", q_b, err_b);
            end else begin
                e = sb_b.pop_front();
                check_done(e, q_b, err_b, res_b);
            end
            done_cnt_b++;
        end
    end

    function automatic longint trace_pack(input bit w);
        longint v = 0;
        if (!w) foreach (tr_a[i]) v = (v << 2) | longint'(tr_a[i]);
        else    foreach (tr_b[i]) v = (v << 2) | longint'(tr_b[i]);
        return v;
    endfunction

    function automatic int trace_count(input bit w, input logic [1:0] code);
        int n = 0;
        if (!w) foreach (tr_a[i]) n += (tr_a[i] == code) ? 1 : 0;
        else    foreach (tr_b[i]) n += (tr_b[i] == code) ? 1 : 0;
        return n;
    endfunction

    function automatic int dcount(input bit w);
        return w ? done_cnt_b : done_cnt_a;
    endfunction

    // Pulse start for one cycle and queue the expected result
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] b,
                         input bit bz, input logic [31:0] q, input bit er,
                         input bit cr, input logic [31:0] r, input int lat,
                         input string nm);
        exp_t e;
        @(negedge clk);
        e.q = q; e.er = er; e.chk_res = cr; e.res = r; e.lat = lat;
        e.e0 = cyc + 1; e.name = nm;
        if (!w) begin
            a_a = a; b_a = b; bz_a = bz; start_a = 1'b1;
            tr_a.delete();
            sb_a.push_back(e);
        end else begin
            a_b = a; b_b = b; bz_b = bz; start_b = 1'b1;
            tr_b.delete();
            sb_b.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; bz_a = 1'b0; bz_b = 1'b0;
    endtask

    task automatic wait_done(input bit w, input int target, input int budget, input string nm);
        int n = 0;
        while (dcount(w) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dcount(w) < target) begin
            vectors++;
            miscmp++;
            $display("FAIL %s timeout: done count %0d, expected %0d", nm, dcount(w), target);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " state"}, st_a, 3);
        chk({nm, " busy"}, busy_a, 0);
        chk({nm, " done"}, done_a, 0);
        chk({nm, " err"}, err_a, 0);
        chk({nm, " quotient"}, q_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start_a = 1'b0; bz_a = 1'b0; a_a = '0; b_a = 32'd1;
        start_b = 1'b0; bz_b = 1'b0; a_b = '0; b_b = 32'd1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // 10 mod 3
        issue(0, 32'd10, 32'd3, 0, 32'd3, 0, 1, 32'd1, 10, "a10b3");
        wait_done(0, 1, 40, "a10b3");
        chk("a10b3 trace length", tr_a.size(), 10);
        chk("a10b3 trace", trace_pack(0), 64'h3777B);

        // zero divisor: no load, quotient and result untouched
        issue(0, 32'd0, 32'd0, 1, 32'd3, 1, 1, 32'd1, 1, "bzero");
        wait_done(0, 2, 10, "bzero");
        chk("bzero trace length", tr_a.size(), 1);
        chk("bzero trace", trace_pack(0), 3);

        // a < b
        issue(0, 32'd2, 32'd5, 0, 32'd0, 0, 1, 32'd2, 4, "a2b5");
        wait_done(0, 3, 20, "a2b5");
        chk("a2b5 trace", trace_pack(0), 64'h3B);
        chk("a2b5 sub count", trace_count(0, CMD_SUB), 0);

        // iteration limit on the MAX_ITER=4 instance
        issue(1, 32'd100, 32'd1, 0, 32'd4, 1, 0, 32'd0, 11, "lim4");
        wait_done(1, 1, 40, "lim4");
        chk("lim4 sub count", trace_count(1, CMD_SUB), 4);
        chk("lim4 final count", trace_count(1, CMD_FINAL), 0);

        // a == b, with an extra start while busy
        issue(0, 32'd7, 32'd7, 0, 32'd1, 0, 1, 32'd0, 6, "a7b7");
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 4, 20, "a7b7");
        repeat (20) @(negedge clk);
        chk("a7b7 done pulses", done_cnt_a, 4);

        // asynchronous reset in the middle of a SUB
        issue(0, 32'd50, 32'd7, 0, 32'd7, 0, 1, 32'd1, 18, "a50b7 aborted");
        n = 0;
        while (st_a != CMD_SUB && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a50b7 reached SUB", st_a, CMD_SUB);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async reset");
        sb_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("async reset no done", done_cnt_a, 4);

        issue(0, 32'd50, 32'd7, 0, 32'd7, 0, 1, 32'd1, 18, "a50b7");
        wait_done(0, 5, 60, "a50b7");
        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb_a.size() + sb_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
